// File: rtl/mips_defs.sv
// ============================================================================
// Module      : mips_defs (package)
// Description : Shared definitions for the MIPS fetch stage: next-PC op
//               codes, default reset PC and fetch FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_defs;

    // Next-PC operation codes driven by execute on redir_op
    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BEQ = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    // Reset PC, which is also the base address of the instruction ROM
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // Fetch FSM states; TRAP is only reachable in address-exception builds
    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/npc_calc.sv
// ============================================================================
// Module      : npc_calc
// Description : Combinational next-PC target calculation for sequential
//               flow, beq, j/jal and jr. Also flags targets that equal the
//               fall-through address so the fetch stage can skip the flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_calc
    import mips_defs::*;
(
    input  logic [1:0]  i_op,
    input  logic [31:0] i_pc,
    input  logic        i_zero,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_index,
    input  logic [31:0] i_rs,
    output logic [31:0] o_target,
    output logic        o_seq_flag
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;

    assign w_pc_plus4  = i_pc + 32'd4;
    // Word offset sign-extended and scaled to bytes
    assign w_br_offset = {{14{i_imm16[15]}}, i_imm16, 2'b00};

    // Select the redirect target; all arithmetic wraps at 32 bits
    always_comb begin
        o_target = w_pc_plus4;
        case (i_op)
            NPC_SEQ: o_target = w_pc_plus4;
            NPC_BEQ: o_target = i_zero ? (w_pc_plus4 + w_br_offset) : w_pc_plus4;
            NPC_J:   o_target = {w_pc_plus4[31:28], i_index, 2'b00};
            NPC_JR:  o_target = i_rs;
            default: o_target = w_pc_plus4;
        endcase
    end

    // A target equal to the fall-through address needs no pipeline flush
    assign o_seq_flag = (o_target == w_pc_plus4);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : MIPS fetch stage. Owns the PC, reads the instruction ROM and
//               presents {pc, instr} to decode through a one-entry registered
//               valid/ready buffer. Redirects from execute flush the buffer
//               unless the target is the fall-through address.
//               Optional macro ADDR_EXC_EN: misaligned or out-of-range fetch
//               addresses raise a sticky exc_addr and park the FSM in TRAP.
//               The ROM array is preloaded by the surrounding environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import mips_defs::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter int          ROM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_link,
    input  logic        redir_valid,
    input  logic [1:0]  redir_op,
    input  logic [31:0] redir_pc,
    input  logic        redir_zero,
    input  logic [15:0] redir_imm16,
    input  logic [25:0] redir_index,
    input  logic [31:0] redir_rs,
    output logic        exc_addr
);

    localparam int unsigned c_rom_aw = $clog2(ROM_WORDS);

    // Instruction memory, word addressed relative to PC_RESET
    logic [31:0] r_rom [ROM_WORDS];

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_out_valid;
    logic [31:0]  r_out_pc;
    logic [31:0]  r_out_instr;

    logic [31:0]         w_target;
    logic                w_seq;
    logic                w_redirect;
    logic                w_fire;
    logic                w_load;
    logic [c_rom_aw-1:0] w_rom_idx;

    npc_calc u_npc_calc (
        .i_op       (redir_op),
        .i_pc       (redir_pc),
        .i_zero     (redir_zero),
        .i_imm16    (redir_imm16),
        .i_index    (redir_index),
        .i_rs       (redir_rs),
        .o_target   (w_target),
        .o_seq_flag (w_seq)
    );

    assign w_redirect = redir_valid && !w_seq;
    assign w_fire     = r_out_valid && out_ready;
    assign w_load     = !r_out_valid || w_fire;
    // Byte offset from the ROM base, low two bits dropped, wrapped to depth
    assign w_rom_idx  = c_rom_aw'((r_pc - PC_RESET) >> 2);

`ifdef ADDR_EXC_EN
    localparam logic [31:0] c_rom_bytes = 32'(ROM_WORDS) * 32'd4;

    logic        r_exc_addr;
    logic [31:0] w_fetch_off;
    logic        w_fetch_bad;

    assign w_fetch_off = r_pc - PC_RESET;
    // Below the base wraps to a large offset, so one compare covers both ends
    assign w_fetch_bad = (r_pc[1:0] != 2'b00) || (w_fetch_off >= c_rom_bytes);
    assign exc_addr    = r_exc_addr;
`else
    assign exc_addr    = 1'b0;
`endif

    // Fetch FSM, PC register and the one-entry output buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_BOOT;
            r_pc        <= PC_RESET;
            r_out_valid <= 1'b0;
            r_out_pc    <= 32'd0;
            r_out_instr <= 32'd0;
`ifdef ADDR_EXC_EN
            r_exc_addr  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                end
                ST_RUN: begin
                    if (w_redirect) begin
                        // Any current entry is taken by decode on a fire; the
                        // flush only affects what follows
                        r_pc        <= w_target;
                        r_out_valid <= 1'b0;
                    end else if (w_load) begin
`ifdef ADDR_EXC_EN
                        if (w_fetch_bad) begin
                            r_out_valid <= 1'b0;
                            r_exc_addr  <= 1'b1;
                            r_state     <= ST_TRAP;
                        end else
`endif
                        begin
                            r_out_pc    <= r_pc;
                            r_out_instr <= r_rom[w_rom_idx];
                            r_out_valid <= 1'b1;
                            r_pc        <= r_pc + 32'd4;
                        end
                    end
                end
`ifdef ADDR_EXC_EN
                ST_TRAP: begin
                    r_out_valid <= 1'b0;
                end
`endif
                default: begin
                    r_state     <= ST_BOOT;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_instr = r_out_instr;
    // No delay slot, so the return address is simply the next word
    assign out_link  = r_out_pc + 32'd4;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. Expected fetch
//               addresses go into a scoreboard queue as stimulus is applied;
//               a monitor pops and compares on every decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;
    import mips_defs::*;

    logic        clk;
    logic        reset;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_link;
    logic        redir_valid;
    logic [1:0]  redir_op;
    logic [31:0] redir_pc;
    logic        redir_zero;
    logic [15:0] redir_imm16;
    logic [25:0] redir_index;
    logic [31:0] redir_rs;
    logic        exc_addr;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] sb_q[$];

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_link    (out_link),
        .redir_valid (redir_valid),
        .redir_op    (redir_op),
        .redir_pc    (redir_pc),
        .redir_zero  (redir_zero),
        .redir_imm16 (redir_imm16),
        .redir_index (redir_index),
        .redir_rs    (redir_rs),
        .exc_addr    (exc_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM image: two words from the reference program, then distinct fill
    function automatic logic [31:0] rom_word(input int idx);
        if (idx == 0) return 32'h3c01_0001;
        if (idx == 1) return 32'h3421_0002;
        return 32'h2400_0000 | 32'(idx);
    endfunction

    function automatic logic [31:0] instr_at(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - 32'h0000_3000) >> 2;
        return rom_word(int'(off & 32'h0000_0FFF));
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_for_pc(input logic [31:0] addr);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clk);
            if (out_valid && out_pc == addr) seen = 1'b1;
        end
        check_eq("wait_pc", seen ? out_pc : 32'hDEAD_BEEF, addr);
    endtask

    task automatic do_redirect(input logic [1:0] op, input logic [31:0] pc, input logic zero,
                               input logic [15:0] imm, input logic [25:0] idx,
                               input logic [31:0] rs);
        redir_valid = 1'b1;
        redir_op    = op;
        redir_pc    = pc;
        redir_zero  = zero;
        redir_imm16 = imm;
        redir_index = idx;
        redir_rs    = rs;
        @(negedge clk);
        redir_valid = 1'b0;
        redir_op    = NPC_SEQ;
    endtask

    // Scoreboard monitor: sample just before the rising edge on every fire
    always begin
        @(negedge clk);
        #4;
        if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = sb_q.pop_front();
                check_eq("sb_pc", out_pc, exp_pc);
                check_eq("sb_instr", out_instr, instr_at(exp_pc));
                check_eq("sb_link", out_link, exp_pc + 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        out_ready   = 1'b1;
        redir_valid = 1'b0;
        redir_op    = NPC_SEQ;
        redir_pc    = 32'd0;
        redir_zero  = 1'b0;
        redir_imm16 = 16'd0;
        redir_index = 26'd0;
        redir_rs    = 32'd0;
        for (int i = 0; i < 4096; i++) dut.r_rom[i] = rom_word(i);

        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_pc", out_pc, 32'd0);
        check_eq("rst_instr", out_instr, 32'd0);
        check_eq("rst_exc", 32'(exc_addr), 32'd0);

        // Release: BOOT for one edge, first entry after the second edge
        reset = 1'b1;
        sb_q.push_back(32'h3000);
        sb_q.push_back(32'h3004);
        sb_q.push_back(32'h3008);
        @(negedge clk);
        check_eq("boot_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("first_valid", 32'(out_valid), 32'd1);
        check_eq("first_pc", out_pc, 32'h3000);
        check_eq("first_link", out_link, 32'h3004);

        // Backpressure on 3008 for three cycles
        wait_for_pc(32'h3008);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_pc", out_pc, 32'h3008);
            check_eq("stall_instr", out_instr, rom_word(2));
        end
        sb_q.push_back(32'h300c);
        out_ready = 1'b1;
        wait_for_pc(32'h300c);

        // beq taken back to 3004
        sb_q.push_back(32'h3004);
        sb_q.push_back(32'h3008);
        sb_q.push_back(32'h300c);
        do_redirect(NPC_BEQ, 32'h300c, 1'b1, 16'hFFFD, 26'd0, 32'd0);
        check_eq("beq_flush", 32'(out_valid), 32'd0);
        wait_for_pc(32'h300c);

        // beq not taken: stream continues without a bubble
        sb_q.push_back(32'h3010);
        do_redirect(NPC_BEQ, 32'h300c, 1'b0, 16'hFFFD, 26'd0, 32'd0);
        check_eq("beq_nt_valid", 32'(out_valid), 32'd1);
        check_eq("beq_nt_pc", out_pc, 32'h3010);

        // j to 3020
        sb_q.push_back(32'h3020);
        do_redirect(NPC_J, 32'h3010, 1'b0, 16'd0, 26'h000_0C08, 32'd0);
        check_eq("j_flush", 32'(out_valid), 32'd0);
        wait_for_pc(32'h3020);

        // jr back to 3008
        sb_q.push_back(32'h3008);
        do_redirect(NPC_JR, 32'h3020, 1'b0, 16'd0, 26'd0, 32'h0000_3008);
        check_eq("jr_flush", 32'(out_valid), 32'd0);
        wait_for_pc(32'h3008);

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("hold_pc", out_pc, 32'h3008);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_pc", out_pc, 32'd0);
        check_eq("arst_instr", out_instr, 32'd0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        sb_q.push_back(32'h3000);
        sb_q.push_back(32'h3004);
        @(negedge clk);
        check_eq("reboot_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("restart_pc", out_pc, 32'h3000);
        wait_for_pc(32'h3004);

        // jr to a misaligned address
`ifndef ADDR_EXC_EN
        sb_q.push_back(32'h3002);
`endif
        do_redirect(NPC_JR, 32'h3004, 1'b0, 16'd0, 26'd0, 32'h0000_3002);
        check_eq("mis_flush", 32'(out_valid), 32'd0);
`ifndef ADDR_EXC_EN
        wait_for_pc(32'h3002);
        check_eq("mis_instr", out_instr, rom_word(0));
        check_eq("mis_exc", 32'(exc_addr), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
`else
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("trap_valid", 32'(out_valid), 32'd0);
            check_eq("trap_exc", 32'(exc_addr), 32'd1);
        end
`endif
        @(negedge clk);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
